// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync preamble followed by payload, MSB first, one bit per clock.
// Optional even-parity trailer bit enabled by defining SEQ_FRAME_TX_PARITY_EN.
module seq_frame_tx #(
    parameter int              PRE_W    = 4,
    parameter logic [PRE_W-1:0] PREAMBLE = 4'b1011,
    parameter int              DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              out,
    output logic              out_valid,
    output logic              done_o
);

    localparam int          MAX_W  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int          CNT_W  = $clog2(MAX_W + 1);
    localparam int unsigned PRE_WU = PRE_W;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA
`ifdef SEQ_FRAME_TX_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               accept;
    logic               pre_next;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    // The counter indexes the bit currently on the line; pre_next is the preamble bit below it.
    always_comb begin
        pre_next = 1'b0;
        for (int unsigned i = 1; i < PRE_WU; i++) begin
            if (cnt_q == CNT_W'(i)) pre_next = PREAMBLE[i-1];
        end
    end

    assign ready_o   = (state_q == IDLE) || done_q;
    assign accept    = valid_i && ready_o;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done_o    = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_d       = par_q;
`endif
        if (accept) begin
            state_d     = PRE;
            cnt_d       = CNT_W'(PRE_W - 1);
            shift_d     = data_i;
            out_d       = PREAMBLE[PRE_W-1];
            out_valid_d = 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_d       = ^data_i;
`endif
        end else if (done_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                PRE: begin
                    out_valid_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = DATA;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        out_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        out_d = pre_next;
                    end
                end
                DATA: begin
                    out_valid_d = 1'b1;
                    if (cnt_q == '0) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                        state_d = PAR;
                        out_d   = par_q;
`else
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
`endif
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        out_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // done is registered, so flag the cycle we are about to enter as the last bit.
`ifdef SEQ_FRAME_TX_PARITY_EN
        done_d = (state_d == PAR);
`else
        done_d = (state_d == DATA) && (cnt_d == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: frame-level queue model plus literal stream checks.
module tb_seq_frame_tx;

    localparam int         PRE_W    = 4;
    localparam logic [3:0] PREAMBLE = 4'b1011;
    localparam int         DATA_W   = 8;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int         L        = 13;
`else
    localparam int         L        = 12;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       ready_o, out, out_valid, done_o;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    seq_frame_tx #(.PRE_W(PRE_W), .PREAMBLE(PREAMBLE), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .out(out), .out_valid(out_valid), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted word becomes a list of frame bits; one bit is popped per clock.
    bit   exp_q[$];
    bit   last_q[$];
    logic m_bit = 1'b0, m_valid = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        logic [15:0] fr;
        if (!rst_n) begin
            exp_q.delete();
            last_q.delete();
            m_bit = 1'b0; m_valid = 1'b0; m_done = 1'b0;
        end else begin
            if (valid_i && (!m_valid || m_done)) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                fr = 16'({PREAMBLE, data_i, ^data_i});
`else
                fr = 16'({PREAMBLE, data_i});
`endif
                for (int i = L - 1; i >= 0; i--) begin
                    exp_q.push_back(fr[i]);
                    last_q.push_back(i == 0);
                end
            end
            if (exp_q.size() > 0) begin
                m_bit = exp_q.pop_front();
                m_done = last_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_bit = 1'b0; m_valid = 1'b0; m_done = 1'b0;
            end
        end
    end

    logic [63:0] cap = '0;
    int ncap = 0, ndone = 0, done_at1 = 0, done_at2 = 0, nrdy_low = 0, cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (out_valid) begin
            cap = {cap[62:0], out};
            ncap++;
        end
        if (done_o) begin
            ndone++;
            if (ndone == 1) done_at1 = cyc;
            else if (ndone == 2) done_at2 = cyc;
        end
        if (!ready_o) nrdy_low++;
        if (chk_en) begin
            chk("out", 64'(out), 64'(m_bit));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("done_o", 64'(done_o), 64'(m_done));
            chk("ready_o", 64'(ready_o), 64'(!m_valid || m_done));
        end
    end

    task automatic clear_cap();
        cap = '0; ncap = 0; ndone = 0; done_at1 = 0; done_at2 = 0; nrdy_low = 0; cyc = 0;
    endtask

    task automatic start_word(input logic [7:0] d);
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = d;
        #1 clear_cap();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_out", 64'(out), 64'(0));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_done", 64'(done_o), 64'(0));
        chk("reset_ready", 64'(ready_o), 64'(1));
        rst_n = 1'b1;

        // Single frame 8'hA5
        start_word(8'hA5);
        @(negedge clk); valid_i = 1'b0;
        repeat (L) @(negedge clk);
        #1;
`ifdef SEQ_FRAME_TX_PARITY_EN
        chk("a5_stream", cap, 64'(13'b1011_1010_0101_0));
`else
        chk("a5_stream", cap, 64'(12'b1011_1010_0101));
`endif
        chk("a5_nbits", 64'(ncap), 64'(L));
        chk("a5_done_cnt", 64'(ndone), 64'(1));
        chk("a5_done_cyc", 64'(done_at1), 64'(L));
        chk("a5_ready_low", 64'(nrdy_low), 64'(L - 1));

        // Back-to-back FF then 00
        start_word(8'hFF);
        @(negedge clk); data_i = 8'h00;
        repeat (L) @(negedge clk);
        valid_i = 1'b0;
        repeat (L) @(negedge clk);
        #1;
`ifdef SEQ_FRAME_TX_PARITY_EN
        chk("b2b_stream", cap, 64'({4'b1011, 8'hFF, 1'b0, 4'b1011, 8'h00, 1'b0}));
`else
        chk("b2b_stream", cap, 64'({4'b1011, 8'hFF, 4'b1011, 8'h00}));
`endif
        chk("b2b_nbits", 64'(ncap), 64'(2 * L));
        chk("b2b_done1", 64'(done_at1), 64'(L));
        chk("b2b_done2", 64'(done_at2), 64'(2 * L));

        // Offer during a frame is ignored until the last-bit cycle
        start_word(8'h3C);
        @(negedge clk); valid_i = 1'b0;
        @(negedge clk); valid_i = 1'b1; data_i = 8'hFF;
        repeat (L - 1) @(negedge clk);
        valid_i = 1'b0;
        repeat (L) @(negedge clk);
        #1;
`ifdef SEQ_FRAME_TX_PARITY_EN
        chk("hold_stream", cap, 64'({4'b1011, 8'h3C, 1'b0, 4'b1011, 8'hFF, 1'b0}));
`else
        chk("hold_stream", cap, 64'({4'b1011, 8'h3C, 4'b1011, 8'hFF}));
`endif
        chk("hold_done2", 64'(done_at2), 64'(2 * L));

        // Reset during cycle 6 aborts the frame
        start_word(8'hA5);
        @(negedge clk); valid_i = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_done", 64'(ndone), 64'(0));
        chk("abort_nbits", 64'(ncap), 64'(6));
        chk("abort_ready", 64'(ready_o), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));

        // Clean restart with 8'h07
        start_word(8'h07);
        @(negedge clk); valid_i = 1'b0;
        repeat (L) @(negedge clk);
        #1;
`ifdef SEQ_FRAME_TX_PARITY_EN
        chk("restart_stream", cap, 64'({4'b1011, 8'h07, 1'b1}));
`else
        chk("restart_stream", cap, 64'({4'b1011, 8'h07}));
`endif
        chk("restart_done_cyc", 64'(done_at1), 64'(L));

        // Idle
        clear_cap();
        repeat (20) @(negedge clk);
        #1;
        chk("idle_nbits", 64'(ncap), 64'(0));
        chk("idle_done", 64'(ndone), 64'(0));
        chk("idle_ready_low", 64'(nrdy_low), 64'(0));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
